// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush control for load-use, memory wait and taken-branch hazards.
// Tracks memory timeouts (sticky MemError) and counts stall and flush cycles.
module hazard_control_unit #(
    parameter int COUNT_W = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [4:0]         IFID_RegisterRn,
    input  logic [4:0]         IFID_RegisterRm,
    input  logic [4:0]         IDEX_RegisterRd,
    input  logic               IDEX_MemRead,
    input  logic               EXMEM_MemAccess,
    input  logic               DMem_Ready,
    input  logic               EXMEM_BranchTaken,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               ControlBubble,
    output logic               PipeStall,
    output logic               IFID_Flush,
    output logic               IDEX_Flush,
    output logic               EXMEM_Flush,
    output logic               MemError,
    output logic [COUNT_W-1:0] StallCount,
    output logic [COUNT_W-1:0] FlushCount
);
    localparam logic [1:0] RUN = 2'd0, MEMWAIT = 2'd1, FLUSH = 2'd2, ERROR = 2'd3;
    logic [1:0] state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic memhold, loaduse, err, hold, flush_ev, bubble_ev;
    always_comb begin
        memhold = EXMEM_MemAccess && !DMem_Ready;
        loaduse = IDEX_MemRead && IDEX_RegisterRd != 5'd31 &&
                  (IDEX_RegisterRd == IFID_RegisterRn || IDEX_RegisterRd == IFID_RegisterRm);
        err = state == ERROR;
        hold = err || memhold;
        flush_ev = !hold && EXMEM_BranchTaken;
        // ID holds a squashed instruction right after a flush, so its sources are meaningless
        bubble_ev = !hold && !EXMEM_BranchTaken && state != FLUSH && loaduse;
        PCWrite = !RESET || !(hold || bubble_ev);
        IFIDWrite = PCWrite;
        ControlBubble = RESET && bubble_ev;
        PipeStall = RESET && hold;
        IFID_Flush = RESET && flush_ev;
        IDEX_Flush = IFID_Flush;
        EXMEM_Flush = IFID_Flush;
        MemError = err;
        wait_nxt = wait_cnt + 8'd1;
        state_nxt = err ? ERROR :
                    memhold ? ((state == MEMWAIT && wait_nxt == 8'(MAX_WAIT)) ? ERROR : MEMWAIT) :
                    EXMEM_BranchTaken ? FLUSH : RUN;
    end
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= RUN;
            wait_cnt <= 8'd0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state <= state_nxt;
            wait_cnt <= (state == MEMWAIT && memhold) ? wait_nxt : 8'd0;
            if (!PCWrite && !(&StallCount)) StallCount <= StallCount + COUNT_W'(1);
            if (IFID_Flush && !(&FlushCount)) FlushCount <= FlushCount + COUNT_W'(1);
        end
    end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the StallCount and FlushCount counters.
REQ-002 SHALL have parameter MAX_WAIT, default 15, the number of MEMWAIT cycles before ERROR (range 1..255).
REQ-003 SHALL have port CLOCK  input  1  the single clock; rising edge active.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IFID_RegisterRn  input  5  first source register of the instruction in ID.
REQ-006 SHALL have port IFID_RegisterRm  input  5  second source register of the instruction in ID.
REQ-007 SHALL have port IDEX_RegisterRd  input  5  destination register of the instruction in EX.
REQ-008 SHALL have port IDEX_MemRead  input  1  the instruction in EX is a load.
REQ-009 SHALL have port EXMEM_MemAccess  input  1  the instruction in MEM accesses data memory.
REQ-010 SHALL have port DMem_Ready  input  1  data memory completes the access this cycle.
REQ-011 SHALL have port EXMEM_BranchTaken  input  1  a branch resolved taken in MEM.
REQ-012 SHALL have port PCWrite  output  1  PC update enable.
REQ-013 SHALL have port IFIDWrite  output  1  IF/ID register write enable.
REQ-014 SHALL have port ControlBubble  output  1  zeroes the ID/EX control fields.
REQ-015 SHALL have port PipeStall  output  1  freezes ID/EX, EX/MEM and MEM/WB.
REQ-016 SHALL have port IFID_Flush, IDEX_Flush and EXMEM_Flush  output  1 each  clear the respective pipeline register.
REQ-017 SHALL have port MemError  output  1  sticky memory-timeout flag.
REQ-018 SHALL have ports StallCount and FlushCount  output  COUNT_W each  performance counters.

Function
REQ-019 SHALL implement FSM states RUN, MEMWAIT, FLUSH and ERROR; outputs are combinational from state and inputs; counters and state are registered.
REQ-020 SHALL define the conditions:
- memhold = EXMEM_MemAccess && !DMem_Ready.
- loaduse = IDEX_MemRead && IDEX_RegisterRd != 31 && (IDEX_RegisterRd == IFID_RegisterRn || IDEX_RegisterRd == IFID_RegisterRm).
REQ-021 SHALL apply priority memhold > EXMEM_BranchTaken > loaduse in RUN, FLUSH and MEMWAIT.
REQ-022 SHALL, on memhold, assert PipeStall=1, PCWrite=0 and IFIDWrite=0 in the same cycle, assert no flushes, and enter MEMWAIT (or remain in it).
REQ-023 SHALL, on a taken branch without memhold, assert IFID_Flush, IDEX_Flush and EXMEM_Flush for exactly that cycle, keep PCWrite=1, and enter FLUSH.
REQ-024 SHALL, on loaduse without a higher-priority event, drive PCWrite=0, IFIDWrite=0 and ControlBubble=1 for that cycle and remain in RUN.
REQ-025 SHALL, with no event, drive PCWrite=1, IFIDWrite=1 and all other control outputs 0.
REQ-026 SHALL mask loaduse in FLUSH (ID holds a flushed bubble); FLUSH lasts one cycle, then the state goes to RUN or follows memhold/branch per REQ-021.
REQ-027 SHALL, in MEMWAIT, increment an 8-bit wait counter each memhold cycle; the counter is cleared on entry from RUN and on exit.
REQ-028 SHALL, in MEMWAIT, evaluate that same cycle as RUN once DMem_Ready=1, so a stalled taken branch flushes on the release cycle.
REQ-029 SHALL enter ERROR when the wait counter equals MAX_WAIT with memhold still true.
REQ-030 SHALL, in ERROR, hold PipeStall=1, PCWrite=0, IFIDWrite=0 and MemError=1, with no exit except reset.
REQ-031 SHALL increment StallCount on every cycle with PCWrite=0, saturating at all-ones.
REQ-032 SHALL increment FlushCount on every cycle with IFID_Flush=1, saturating at all-ones.
REQ-033 SHALL treat register 31 (XZR) as never producing a load-use hazard.

Reset
REQ-034 SHALL, while RESET=0 and regardless of inputs, force the state to RUN, wait counter=0, StallCount=0, FlushCount=0 and MemError=0.
REQ-035 SHALL, while RESET=0, force PCWrite=1, IFIDWrite=1 and all other control outputs 0.
REQ-036 SHALL take effect immediately on reset assertion from any state, including mid-MEMWAIT and ERROR; the first post-reset rising edge evaluates from RUN.

Verification
REQ-037 SHALL cover load-use: IDEX_MemRead=1, IDEX_RegisterRd=5, IFID_RegisterRm=5 -> one cycle of PCWrite=0, IFIDWrite=0, ControlBubble=1; StallCount=1.
REQ-038 SHALL cover XZR: the same stimulus with Rd=Rn=31 -> no stall, PCWrite=1.
REQ-039 SHALL cover memory wait: EXMEM_MemAccess=1, DMem_Ready=0 for 3 cycles then 1 -> PipeStall high for 3 cycles, low on the release cycle; StallCount=3.
REQ-040 SHALL cover branch during a wait: EXMEM_BranchTaken=1 held through a 2-cycle memhold -> flushes only on the release cycle, FlushCount=1, next cycle loaduse masked.
REQ-041 SHALL cover timeout: DMem_Ready=0 held with MAX_WAIT=15 -> ERROR after 15 wait cycles, MemError=1 sticky; RESET pulse -> MemError=0, PCWrite=1.
REQ-042 SHALL cover simultaneous events: memhold, branch and loaduse together -> only PipeStall asserted, no flush, no ControlBubble.
